// File: rtl/mux4_rr_arbiter_pkg.sv
// Shared types and sizes for the 4-requester round-robin mux arbiter.
package mux4_arb_pkg;
  localparam int unsigned N_REQ          = 4;
  localparam int unsigned SEL_W          = 2;
  localparam int unsigned DATA_W_DEFAULT = 16;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;
endpackage

// File: rtl/mux4_rr_arbiter_if.sv
// Request/data/grant bundle between four requesters and the shared mux arbiter.
interface mux4_rr_arbiter_if #(
  parameter int unsigned DATA_W = 16
);
  logic [3:0]        i_req;
  logic [DATA_W-1:0] i_data_0;
  logic [DATA_W-1:0] i_data_1;
  logic [DATA_W-1:0] i_data_2;
  logic [DATA_W-1:0] i_data_3;
  logic [3:0]        o_grant;
  logic [1:0]        o_sel;
  logic              o_valid;
  logic [DATA_W-1:0] o_data;

  modport slave (
    input  i_req, i_data_0, i_data_1, i_data_2, i_data_3,
    output o_grant, o_sel, o_valid, o_data
  );

  modport master (
    output i_req, i_data_0, i_data_1, i_data_2, i_data_3,
    input  o_grant, o_sel, o_valid, o_data
  );
endinterface

// File: rtl/mux4_rr_arbiter_rr_pick.sv
// Combinational rotate-priority picker: first eligible request at ptr, ptr+1, .. ptr+3.
module rr_pick
  import mux4_arb_pkg::*;
(
  input  logic [N_REQ-1:0] req_i,
  input  logic [SEL_W-1:0] ptr_i,
  input  logic [N_REQ-1:0] excl_i,
  output logic             found_o,
  output logic [SEL_W-1:0] idx_o
);
  logic [N_REQ-1:0] elig;
  logic [SEL_W-1:0] cand;

  assign elig = req_i & ~excl_i;

  // Scan from the farthest offset down so the closest-to-pointer match wins.
  always_comb begin
    found_o = 1'b0;
    idx_o   = '0;
    cand    = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      cand = ptr_i + SEL_W'(i);
      if (elig[cand]) begin
        found_o = 1'b1;
        idx_o   = cand;
      end
    end
  end
endmodule

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter with bounded hold driving a registered 4:1 data mux.
// Optional MUX4_ARB_LOCK_EN adds i_lock to suspend the hold limit.
module mux4_rr_arbiter
  import mux4_arb_pkg::*;
#(
  parameter int unsigned DATA_W   = DATA_W_DEFAULT,
  parameter int unsigned MAX_HOLD = 4,
  parameter int unsigned CNT_W    = 3
) (
  input logic              i_clk,
  input logic              i_rst_n,
`ifdef MUX4_ARB_LOCK_EN
  input logic              i_lock,
`endif
  mux4_rr_arbiter_if.slave bus
);
  state_e            state_q;
  logic [N_REQ-1:0]  grant_q;
  logic [SEL_W-1:0]  sel_q;
  logic [SEL_W-1:0]  ptr_q;
  logic [CNT_W-1:0]  hold_q;
  logic              valid_q;
  logic [DATA_W-1:0] data_q;

  logic              found_any_c, found_oth_c, lock_c, cur_req_c, hold_max_c;
  logic [SEL_W-1:0]  idx_any_c, idx_oth_c;
  logic [DATA_W-1:0] data_mux_c;

`ifdef MUX4_ARB_LOCK_EN
  assign lock_c = i_lock;
`else
  assign lock_c = 1'b0;
`endif

  rr_pick u_pick_any (
    .req_i   (bus.i_req),
    .ptr_i   (ptr_q),
    .excl_i  ('0),
    .found_o (found_any_c),
    .idx_o   (idx_any_c)
  );

  rr_pick u_pick_oth (
    .req_i   (bus.i_req),
    .ptr_i   (ptr_q),
    .excl_i  (grant_q),
    .found_o (found_oth_c),
    .idx_o   (idx_oth_c)
  );

  assign cur_req_c  = |(bus.i_req & grant_q);
  assign hold_max_c = (hold_q == CNT_W'(MAX_HOLD));

  always_comb begin
    case (sel_q)
      2'd0:    data_mux_c = bus.i_data_0;
      2'd1:    data_mux_c = bus.i_data_1;
      2'd2:    data_mux_c = bus.i_data_2;
      default: data_mux_c = bus.i_data_3;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      grant_q <= '0;
      sel_q   <= '0;
      ptr_q   <= '0;
      hold_q  <= '0;
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          valid_q <= 1'b0;
          if (found_any_c) begin
            state_q <= GRANT;
            grant_q <= N_REQ'(1) << idx_any_c;
            sel_q   <= idx_any_c;
            ptr_q   <= idx_any_c + SEL_W'(1);
            hold_q  <= CNT_W'(1);
          end
        end
        default: begin
          valid_q <= 1'b1;
          data_q  <= data_mux_c;
          // Switch when the holder is done, or it has used its slot and someone waits.
          if ((!cur_req_c || (hold_max_c && !lock_c)) && found_oth_c) begin
            grant_q <= N_REQ'(1) << idx_oth_c;
            sel_q   <= idx_oth_c;
            ptr_q   <= idx_oth_c + SEL_W'(1);
            hold_q  <= CNT_W'(1);
          end else if (!cur_req_c) begin
            state_q <= IDLE;
            grant_q <= '0;
          end else if (!hold_max_c) begin
            hold_q  <= hold_q + CNT_W'(1);
          end
        end
      endcase
    end
  end

  assign bus.o_grant = grant_q;
  assign bus.o_sel   = sel_q;
  assign bus.o_valid = valid_q;
  assign bus.o_data  = data_q;
endmodule
